irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Hart-side machine-mode interrupt controller; receiving end of the CLINT/PLIC interrupt lines.
//  Holds mstatus.MIE/MPIE, mie and mip.
//  Prioritises pending, enabled interrupts and raises a registered trap request to the pipeline.
//  Sequences trap entry and mret through a 3-state FSM.
// PARAMETERS
//  XLEN_P     `XLEN   CSR data width (32).
//  MSTATUS_A  12'h300 mstatus address.
//  MIE_A      12'h304 mie address.
//  MIP_A      12'h344 mip address.
// PORTS
//  i_clk          in   1       clock; single clock domain.
//  i_rst          in   1       reset; synchronous, active-low.
//  i_tip          in   1       machine timer interrupt level (CLINT o_tip).
//  i_eip          in   1       machine external interrupt level.
//  i_sip          in   1       machine software interrupt level (only with IRQ_SOFT_EN).
//  i_csr_wen      in   1       CSR write strobe.
//  i_csr_addr     in   12      CSR address.
//  i_csr_wrdata   in   XLEN    CSR write data.
//  o_csr_rddata   out  XLEN    CSR read data; combinational, 0 for unmapped addresses.
//  o_irq_req      out  1       trap request to pipeline; registered.
//  o_irq_cause    out  XLEN    mcause value; valid while o_irq_req=1.
//  i_irq_ack      in   1       pipeline took the trap at an instruction boundary.
//  i_mret         in   1       mret retiring (one-cycle pulse).
//  o_in_trap      out  1       FSM is in TRAP.
// BEHAVIOUR
//  Reset (i_rst=0 at a clock edge):
//   - MIE=0, MPIE=0, mie=0, state=IDLE.
//   - o_irq_req=0, o_irq_cause=0, o_in_trap=0.
//  mstatus:
//   - Bit 3 is MIE, bit 7 is MPIE.
//   - Bits 12:11 (MPP) read 2'b11.
//   - All other bits read 0 and ignore writes.
//  mie:
//   - Bits 11 (MEIE), 7 (MTIE) and 3 (MSIE) are writable.
//   - All other bits read 0.
//  mip:
//   - Bit 11 = i_eip, bit 7 = i_tip, bit 3 = i_sip, sampled live.
//   - mip is read-only; writes to it are ignored.
//  Request condition: pend = mip & mie, with MIE=1 and pend!=0.
//  Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
//  Cause encoding: o_irq_cause = {1'b1, (XLEN-5)'b0, code[3:0]}.
//  FSM:
//   - IDLE: when the request condition holds, go to REQ next edge and set o_irq_req=1 and the cause.
//     Latency from an input rising to o_irq_req is 1 clock.
//   - REQ, i_irq_ack=1: MPIE<=MIE, MIE<=0, o_irq_req<=0, go to TRAP.
//   - REQ, no ack, condition lost (input dropped, mie or MIE cleared): o_irq_req<=0, go to IDLE.
//     The request is withdrawn, never left stale.
//   - REQ, higher-priority source arrives: o_irq_cause updates on the next edge; o_irq_req stays 1.
//   - TRAP, i_mret=1: MIE<=MPIE, MPIE<=1, go to IDLE.
//   - TRAP: new requests are blocked because MIE=0; o_in_trap=1.
//  Simultaneous events:
//   - mret in IDLE or REQ applies the same MIE/MPIE update; the state is re-evaluated the next cycle.
//   - CSR write to mstatus in the same cycle as ack or mret: the ack/mret update of MIE/MPIE wins.
//     The CSR write still updates all other fields.
//   - i_irq_ack outside REQ is ignored.
//  Reset asserted mid-operation (any state): registers go to their reset values at that edge.
//   o_irq_req drops on the same edge.
// CONFIGURATION
//  IRQ_SOFT_EN defined: i_sip port exists; MSIE bit is writable and MSIP is reported.
//  IRQ_SOFT_EN undefined:
//   - i_sip is absent; mip bit 3 and mie bit 3 read 0.
//   - Writes to mie bit 3 are dropped; code 3 is never produced.
// STRUCTURE
//  Shared defines.vh holds:
//   - CSR address constants: CSR_MSTATUS, CSR_MIE, CSR_MIP.
//   - Cause codes: IRQ_MEI=11, IRQ_MTI=7, IRQ_MSI=3.
//   - FSM state encodings: IRQ_IDLE, IRQ_REQ, IRQ_TRAP.
//  One sub-module, irq_prio_enc: combinational; pend[11:0] in; valid and code[3:0] out.
// TESTING
//  1. Reset, write mie=0x80, mstatus=0x8, raise i_tip -> o_irq_req=1 one clock later,
//     o_irq_cause=0x80000007.
//  2. i_tip and i_eip both high, mie=0x880 -> cause 0x8000000B.
//     Ack -> TRAP, mstatus reads 0x1880 (MPIE=1, MIE=0, MPP=3).
//  3. In REQ, drop i_tip before ack -> o_irq_req=0 next edge, state IDLE, mstatus unchanged.
//  4. In TRAP, pulse i_mret with i_tip still high -> MIE=1, MPIE=1.
//     o_irq_req re-asserts 1 clock after returning to IDLE.
//  5. Same cycle: ack plus CSR write mstatus=0x8 -> MIE=0, MPIE=1 (ack wins).
//  6. Without IRQ_SOFT_EN: write mie=0xFFFFFFFF -> read-back 0x880.
//     With IRQ_SOFT_EN -> read-back 0x888; i_sip with i_tip gives cause 3.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the machine-mode interrupt controller.
// Holds CSR addresses, cause codes, the mie write mask and the FSM state type.
// Build option: IRQ_SOFT_EN adds the machine software interrupt (MSIE/MSIP, code 3).
package irq_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned PEND_W = 12;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [CODE_W-1:0] IRQ_MEI = 4'd11;
    localparam logic [CODE_W-1:0] IRQ_MTI = 4'd7;
    localparam logic [CODE_W-1:0] IRQ_MSI = 4'd3;

    localparam int unsigned MSTATUS_MIE_B  = 3;
    localparam int unsigned MSTATUS_MPIE_B = 7;

`ifdef IRQ_SOFT_EN
    localparam logic [PEND_W-1:0] MIE_WMASK = 12'h888;
`else
    localparam logic [PEND_W-1:0] MIE_WMASK = 12'h880;
`endif

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_TRAP = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the pending vector: MEI > MSI > MTI.
// Ports: pend[11:0] in; valid (any source pending) and code[3:0] (winning cause) out.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [PEND_W-1:0] pend,
    output logic              valid,
    output logic [CODE_W-1:0] code
);

    // Only bits 11, 7 and 3 can ever be set; the rest are ignored.
    logic unused_pend;
    assign unused_pend = ^{pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        valid = 1'b0;
        code  = '0;
        if (pend[11]) begin
            valid = 1'b1;
            code  = IRQ_MEI;
        end else if (pend[3]) begin
            valid = 1'b1;
            code  = IRQ_MSI;
        end else if (pend[7]) begin
            valid = 1'b1;
            code  = IRQ_MTI;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Hart-side machine-mode interrupt controller.
// Holds mstatus.MIE/MPIE, mie and the live mip view; raises a registered trap request
// with its mcause, and sequences trap entry / mret through IDLE -> REQ -> TRAP.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_tip, i_eip, i_sip (i_sip only when IRQ_SOFT_EN is defined) : interrupt levels
//   i_csr_wen, i_csr_addr, i_csr_wrdata, o_csr_rddata (combinational) : CSR access
//   o_irq_req, o_irq_cause, i_irq_ack : trap handshake with the pipeline
//   i_mret : mret retiring; o_in_trap : FSM is in TRAP
// Build option: IRQ_SOFT_EN enables the software interrupt source.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN_P    = XLEN,
    parameter logic [11:0] MSTATUS_A = CSR_MSTATUS,
    parameter logic [11:0] MIE_A     = CSR_MIE,
    parameter logic [11:0] MIP_A     = CSR_MIP
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tip,
    input  logic              i_eip,
`ifdef IRQ_SOFT_EN
    input  logic              i_sip,
`endif
    input  logic              i_csr_wen,
    input  logic [11:0]       i_csr_addr,
    input  logic [XLEN_P-1:0] i_csr_wrdata,
    output logic [XLEN_P-1:0] o_csr_rddata,
    output logic              o_irq_req,
    output logic [XLEN_P-1:0] o_irq_cause,
    input  logic              i_irq_ack,
    input  logic              i_mret,
    output logic              o_in_trap
);

    irq_state_t        state;
    logic              mst_mie;
    logic              mst_mpie;
    logic [PEND_W-1:0] mie_r;
    logic [PEND_W-1:0] mip_w;
    logic [PEND_W-1:0] pend;
    logic              enc_valid;
    logic [CODE_W-1:0] enc_code;
    logic              req_cond;
    logic [XLEN_P-1:0] cause_w;
    logic              wr_mstatus;
    logic              wr_mie;

    logic unused_wrdata;
    assign unused_wrdata = ^{i_csr_wrdata[XLEN_P-1:PEND_W]};

    // Live pending view of the interrupt lines.
    always_comb begin
        mip_w     = '0;
        mip_w[11] = i_eip;
        mip_w[7]  = i_tip;
`ifdef IRQ_SOFT_EN
        mip_w[3]  = i_sip;
`endif
    end

    assign pend     = mip_w & mie_r;
    assign req_cond = mst_mie && enc_valid;
    assign cause_w  = {1'b1, {(XLEN_P-CODE_W-1){1'b0}}, enc_code};

    assign wr_mstatus = i_csr_wen && (i_csr_addr == MSTATUS_A);
    assign wr_mie     = i_csr_wen && (i_csr_addr == MIE_A);

    irq_prio_enc u_prio (
        .pend  (pend),
        .valid (enc_valid),
        .code  (enc_code)
    );

    // CSR read mux; MPP is hardwired to machine mode.
    always_comb begin
        o_csr_rddata = '0;
        if (i_csr_addr == MSTATUS_A) begin
            o_csr_rddata[12:11]          = 2'b11;
            o_csr_rddata[MSTATUS_MPIE_B] = mst_mpie;
            o_csr_rddata[MSTATUS_MIE_B]  = mst_mie;
        end else if (i_csr_addr == MIE_A) begin
            o_csr_rddata[PEND_W-1:0] = mie_r;
        end else if (i_csr_addr == MIP_A) begin
            o_csr_rddata[PEND_W-1:0] = mip_w;
        end
    end

    // CSR state, MIE/MPIE stacking and the trap FSM.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= IRQ_IDLE;
            mst_mie     <= 1'b0;
            mst_mpie    <= 1'b0;
            mie_r       <= '0;
            o_irq_req   <= 1'b0;
            o_irq_cause <= '0;
            o_in_trap   <= 1'b0;
        end else begin
            if (wr_mie) begin
                mie_r <= i_csr_wrdata[PEND_W-1:0] & MIE_WMASK;
            end

            // Trap entry / mret stacking overrides a concurrent mstatus write.
            if (state == IRQ_REQ && i_irq_ack) begin
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (i_mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mst_mie  <= i_csr_wrdata[MSTATUS_MIE_B];
                mst_mpie <= i_csr_wrdata[MSTATUS_MPIE_B];
            end

            case (state)
                IRQ_IDLE: begin
                    if (req_cond) begin
                        state       <= IRQ_REQ;
                        o_irq_req   <= 1'b1;
                        o_irq_cause <= cause_w;
                    end
                end
                IRQ_REQ: begin
                    if (i_irq_ack) begin
                        state     <= IRQ_TRAP;
                        o_irq_req <= 1'b0;
                        o_in_trap <= 1'b1;
                    end else if (!req_cond) begin
                        // Withdraw rather than leave a stale request.
                        state     <= IRQ_IDLE;
                        o_irq_req <= 1'b0;
                    end else begin
                        o_irq_cause <= cause_w;
                    end
                end
                IRQ_TRAP: begin
                    if (i_mret) begin
                        state     <= IRQ_IDLE;
                        o_in_trap <= 1'b0;
                    end
                end
                default: begin
                    state     <= IRQ_IDLE;
                    o_irq_req <= 1'b0;
                    o_in_trap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the interrupt rules.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tip = 1'b0;
    logic        eip = 1'b0;
    logic        sip = 1'b0;
    logic        wen = 1'b0;
    logic [11:0] addr = 12'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] rddata;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic        in_trap;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          m_mie;
    bit          m_mpie;
    logic [31:0] m_mie_r;
    bit          m_req;
    bit          m_trap;
    logic [31:0] m_cause;

`ifdef IRQ_SOFT_EN
    localparam logic [31:0] MIE_MASK = 32'h888;
    localparam bit          SOFT     = 1'b1;
`else
    localparam logic [31:0] MIE_MASK = 32'h880;
    localparam bit          SOFT     = 1'b0;
`endif

    always #5 clk = ~clk;

    irq_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_tip        (tip),
        .i_eip        (eip),
`ifdef IRQ_SOFT_EN
        .i_sip        (sip),
`endif
        .i_csr_wen    (wen),
        .i_csr_addr   (addr),
        .i_csr_wrdata (wdata),
        .o_csr_rddata (rddata),
        .o_irq_req    (irq_req),
        .o_irq_cause  (irq_cause),
        .i_irq_ack    (ack),
        .i_mret       (mret),
        .o_in_trap    (in_trap)
    );

    function automatic logic [31:0] model_mip();
        logic [31:0] v;
        v = 32'h0;
        if (eip) v = v + 32'h800;
        if (tip) v = v + 32'h80;
        if (SOFT && sip) v = v + 32'h8;
        return v;
    endfunction

    // Highest-priority pending cause code, or -1 when nothing is pending.
    function automatic int best_code(input logic [31:0] p);
        int order [3] = '{11, 3, 7};
        foreach (order[k]) begin
            if (p[order[k]]) return order[k];
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h304: return m_mie_r;
            12'h344: return model_mip();
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int          code;
        bit          cond;
        bit          n_mie, n_mpie, n_req, n_trap;
        logic [31:0] n_mie_r, n_cause;
        if (!rst_n) begin
            m_mie = 0; m_mpie = 0; m_mie_r = 0; m_req = 0; m_trap = 0; m_cause = 0;
            return;
        end
        code    = best_code(model_mip() & m_mie_r);
        cond    = m_mie && (code >= 0);
        n_mie   = m_mie;   n_mpie  = m_mpie;
        n_req   = m_req;   n_trap  = m_trap;
        n_mie_r = m_mie_r; n_cause = m_cause;
        if (wen && addr == 12'h304) n_mie_r = wdata & MIE_MASK;
        if (m_req && ack) begin
            n_mpie = m_mie; n_mie = 0;
        end else if (mret) begin
            n_mie = m_mpie; n_mpie = 1;
        end else if (wen && addr == 12'h300) begin
            n_mie = wdata[3]; n_mpie = wdata[7];
        end
        if (m_trap) begin
            if (mret) n_trap = 0;
        end else if (m_req) begin
            if (ack) begin
                n_req = 0; n_trap = 1;
            end else if (!cond) begin
                n_req = 0;
            end else begin
                n_cause = 32'h8000_0000 + 32'(code);
            end
        end else if (cond) begin
            n_req   = 1;
            n_cause = 32'h8000_0000 + 32'(code);
        end
        m_mie = n_mie; m_mpie = n_mpie; m_mie_r = n_mie_r;
        m_req = n_req; m_trap = n_trap; m_cause = n_cause;
    endtask

    // One clock: update model, wait past the edge, compare registered outputs.
    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".req"}, 32'(irq_req), 32'(m_req));
        check({tag, ".in_trap"}, 32'(in_trap), 32'(m_trap));
        if (m_req) check({tag, ".cause"}, irq_cause, m_cause);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        cyc("csr_wr");
        wen = 1'b0;
    endtask

    task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check({tag, ".model"}, rddata, model_read(a));
        check(tag, rddata, exp);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        cyc("rst0");
        cyc("rst1");
        check("rst_cause", irq_cause, 32'h0);
        rst_n = 1'b1;
        csr_rd("rst_mstatus", 12'h300, 32'h1800);
        csr_rd("rst_mie", 12'h304, 32'h0);

        // 1: timer interrupt, one clock latency
        csr_wr(12'h304, 32'h80);
        csr_wr(12'h300, 32'h8);
        tip = 1'b1;
        cyc("t1");
        check("t1_req", 32'(irq_req), 32'h1);
        check("t1_cause", irq_cause, 32'h8000_0007);

        // 2: external overrides timer while requesting, then ack
        csr_wr(12'h304, 32'h880);
        eip = 1'b1;
        cyc("t2");
        check("t2_cause", irq_cause, 32'h8000_000B);
        ack = 1'b1;
        cyc("t2_ack");
        ack = 1'b0;
        check("t2_in_trap", 32'(in_trap), 32'h1);
        csr_rd("t2_mstatus", 12'h300, 32'h1880);
        cyc("t2_blocked");
        check("t2_blocked_req", 32'(irq_req), 32'h0);

        // 4: mret with timer still high re-raises one clock after IDLE
        eip  = 1'b0;
        mret = 1'b1;
        cyc("t4_mret");
        mret = 1'b0;
        check("t4_in_trap", 32'(in_trap), 32'h0);
        check("t4_req0", 32'(irq_req), 32'h0);
        csr_rd("t4_mstatus", 12'h300, 32'h1888);
        cyc("t4_rearm");
        check("t4_req1", 32'(irq_req), 32'h1);
        check("t4_cause", irq_cause, 32'h8000_0007);

        // 3: source drops before ack -> request withdrawn
        tip = 1'b0;
        cyc("t3_drop");
        check("t3_req", 32'(irq_req), 32'h0);
        csr_rd("t3_mstatus", 12'h300, 32'h1888);
        cyc("t3_idle");

        // 5: ack and mstatus write in the same cycle -> ack wins
        tip = 1'b1;
        cyc("t5_req");
        ack = 1'b1; wen = 1'b1; addr = 12'h300; wdata = 32'h8;
        cyc("t5_ack");
        ack = 1'b0; wen = 1'b0;
        csr_rd("t5_mstatus", 12'h300, 32'h1880);
        mret = 1'b1;
        cyc("t5_mret");
        mret = 1'b0;
        csr_rd("t5_mstatus_ret", 12'h300, 32'h1888);
        tip = 1'b0;
        cyc("t5_settle");
        cyc("t5_settle2");

        // 6: mie write mask, read-only mip, unmapped address, mstatus mask
        csr_wr(12'h304, 32'hFFFF_FFFF);
        csr_rd("t6_mie", 12'h304, MIE_MASK);
        eip = 1'b1;
        csr_wr(12'h344, 32'h0);
        csr_rd("t6_mip", 12'h344, 32'h800);
        csr_rd("t6_unmapped", 12'h123, 32'h0);
        ack = 1'b1;
        cyc("t6_ack");
        ack = 1'b0;
        eip = 1'b0;
        csr_wr(12'h300, 32'hFFFF_FFFF);
        csr_rd("t6_mstatus", 12'h300, 32'h1888);
        mret = 1'b1;
        cyc("t6_mret");
        mret = 1'b0;
        cyc("t6_idle");
`ifdef IRQ_SOFT_EN
        sip = 1'b1; tip = 1'b1;
        cyc("t6_soft");
        check("t6_soft_cause", irq_cause, 32'h8000_0003);
        sip = 1'b0; tip = 1'b0;
        cyc("t6_soft_drop");
`endif

        // Reset in the middle of a request
        tip = 1'b1;
        cyc("rst_mid_req");
        check("rst_mid_pre", 32'(irq_req), 32'h1);
        rst_n = 1'b0;
        cyc("rst_mid");
        check("rst_mid_req", 32'(irq_req), 32'h0);
        rst_n = 1'b1;
        tip = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) tip = ~tip;
            if ($urandom_range(0, 5) == 0) eip = ~eip;
            if ($urandom_range(0, 5) == 0) sip = ~sip;
            wen = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       addr = 12'h300;
                1:       addr = 12'h304;
                2:       addr = 12'h344;
                default: addr = 12'($urandom);
            endcase
            wdata = $urandom;
            ack   = ($urandom_range(0, 2) == 0);
            mret  = ($urandom_range(0, 11) == 0);
            #1;
            total++;
            assert (rddata === model_read(addr)) else begin
                bad++;
                $error("FAIL rnd_rd: addr=%h observed=%h expected=%h", addr, rddata, model_read(addr));
            end
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
